// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: decode-field inputs and datapath control outputs of the
// multi-cycle control FSM. The control unit uses the master modport; the
// datapath (or a testbench standing in for it) uses the slave modport.
interface mc_control_fsm_if #(
  parameter int OPCODE_W   = 4,
  parameter int FUNCT_W    = 6,
  parameter int ALUOP_W    = 4,
  parameter int INST_CNT_W = 16
) ();

  // Decode fields and memory handshake
  logic [OPCODE_W-1:0]   opcode;
  logic [FUNCT_W-1:0]    funct;
  logic                  mem_ready;

  // Datapath controls
  logic                  PCWrite;
  logic                  PCWriteCond;
  logic                  IorD;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  MemtoReg;
  logic                  IRWrite;
  logic                  RegWrite;
  logic [1:0]            RegDst;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            PCSource;
  logic [ALUOP_W-1:0]    ALUOp;
  logic                  output_port_en;

  // Status
  logic                  illegal_inst;
  logic                  is_halted;
  logic [INST_CNT_W-1:0] num_inst;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           output_port_en, illegal_inst, is_halted, num_inst
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           output_port_en, illegal_inst, is_halted, num_inst
  );

endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control FSM for the 16-bit TSC-style CPU.
// States IF/ID/EX/MEM/WB/HALT, variable-latency memory via mem_ready,
// HLT/WWD support, illegal-instruction pulse and a retired-instruction count.
// Optional macro CTRL_PERF_CNT_EN adds cycle_cnt and stall_cnt outputs.
module mc_control_fsm #(
  parameter int OPCODE_W   = 4,
  parameter int FUNCT_W    = 6,
  parameter int ALUOP_W    = 4,
  parameter int INST_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.master   bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  // Opcode field encodings
  localparam logic [OPCODE_W-1:0] OPC_BNE   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OPC_BGZ   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OPC_BLZ   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OPC_ADI   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OPC_ORI   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OPC_LHI   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OPC_LWD   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OPC_SWD   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OPC_JMP   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OPC_JAL   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(15);

  // R-type funct encodings
  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(1);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(2);
  localparam logic [FUNCT_W-1:0] F_ORR = FUNCT_W'(3);
  localparam logic [FUNCT_W-1:0] F_NOT = FUNCT_W'(4);
  localparam logic [FUNCT_W-1:0] F_TCP = FUNCT_W'(5);
  localparam logic [FUNCT_W-1:0] F_SHL = FUNCT_W'(6);
  localparam logic [FUNCT_W-1:0] F_SHR = FUNCT_W'(7);
  localparam logic [FUNCT_W-1:0] F_JPR = FUNCT_W'(25);
  localparam logic [FUNCT_W-1:0] F_JRL = FUNCT_W'(26);
  localparam logic [FUNCT_W-1:0] F_WWD = FUNCT_W'(28);
  localparam logic [FUNCT_W-1:0] F_HLT = FUNCT_W'(29);

  // ALU operation encodings (OP_* set)
  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_NOT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_TCP = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_SHL = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_SHR = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] OP_ID  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] OP_BNE = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] OP_BEQ = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] OP_BGZ = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] OP_BLZ = ALUOP_W'(12);

  // Mux select encodings
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_R2 = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS = 2'b01, SRCA_IMMHI = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_JUMP = 2'b01, PCS_BR = 2'b10, PCS_RS = 2'b11;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               output_port_en;
    logic               illegal_inst;
    logic               is_halted;
  } ctrl_t;

  state_e                state_q, state_d;
  logic [INST_CNT_W-1:0] num_inst_q, num_inst_d;
  ctrl_t                 ctrl;

  // R-type ALU funct to ALU operation
  function automatic logic [ALUOP_W-1:0] r_alu_op(input logic [FUNCT_W-1:0] f);
    case (f)
      F_SUB:   return OP_SUB;
      F_AND:   return OP_AND;
      F_ORR:   return OP_OR;
      F_NOT:   return OP_NOT;
      F_TCP:   return OP_TCP;
      F_SHL:   return OP_SHL;
      F_SHR:   return OP_SHR;
      default: return OP_ADD;
    endcase
  endfunction

  // Next state and combinational control outputs from state, opcode, funct, mem_ready
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_ID;
      end
      S_ID: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = OP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_ALU;
        state_d        = S_EX;
        case (bus.opcode)
          OPC_JMP: begin
            ctrl.pc_source = PCS_JUMP;
            state_d        = S_IF;
          end
          OPC_JAL: begin
            ctrl.pc_source = PCS_JUMP;
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = DST_R2;
            state_d        = S_IF;
          end
          OPC_RTYPE: begin
            case (bus.funct)
              F_ADD, F_SUB, F_AND, F_ORR, F_NOT, F_TCP, F_SHL, F_SHR: ;
              F_JPR: begin
                ctrl.pc_source = PCS_RS;
                state_d        = S_IF;
              end
              F_JRL: begin
                ctrl.pc_source = PCS_RS;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = DST_R2;
                state_d        = S_IF;
              end
              F_WWD: begin
                ctrl.output_port_en = 1'b1;
                state_d             = S_IF;
              end
              F_HLT: begin
                ctrl.pc_write = 1'b0;
                state_d       = S_HALT;
              end
              default: begin
                ctrl.illegal_inst = 1'b1;
                state_d           = S_IF;
              end
            endcase
          end
          OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ, OPC_ADI, OPC_ORI,
          OPC_LHI, OPC_LWD, OPC_SWD: ;
          default: begin
            ctrl.illegal_inst = 1'b1;
            state_d           = S_IF;
          end
        endcase
      end
      S_EX: begin
        state_d = S_WB;
        case (bus.opcode)
          OPC_RTYPE: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = r_alu_op(bus.funct);
          end
          OPC_ADI, OPC_ORI: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = (bus.opcode == OPC_ORI) ? OP_OR : OP_ADD;
          end
          OPC_LHI: begin
            ctrl.alu_src_a = SRCA_IMMHI;
            ctrl.alu_op    = OP_ID;
          end
          OPC_LWD, OPC_SWD: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = OP_ADD;
            state_d        = S_MEM;
          end
          OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: begin
            ctrl.alu_src_a     = SRCA_RS;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_BR;
            state_d            = S_IF;
            case (bus.opcode)
              OPC_BNE: ctrl.alu_op = OP_BNE;
              OPC_BEQ: ctrl.alu_op = OP_BEQ;
              OPC_BGZ: ctrl.alu_op = OP_BGZ;
              default: ctrl.alu_op = OP_BLZ;
            endcase
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = (bus.opcode == OPC_LWD);
        ctrl.mem_write = (bus.opcode == OPC_SWD);
        if (bus.mem_ready) state_d = (bus.opcode == OPC_LWD) ? S_WB : S_IF;
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (bus.opcode == OPC_RTYPE) ? DST_RD : DST_RT;
        ctrl.mem_to_reg = (bus.opcode == OPC_LWD);
        state_d         = S_IF;
      end
      S_HALT: ctrl.is_halted = 1'b1;
      default: state_d = S_IF;
    endcase
    // Reset abandons whatever the current state was doing this very cycle.
    if (reset) ctrl = '0;
  end

  // Retire count: one per return to IF from a non-fetch, non-halt state
  always_comb begin
    num_inst_d = num_inst_q;
    if ((state_q inside {S_ID, S_EX, S_MEM, S_WB}) && state_d == S_IF)
      num_inst_d = num_inst_q + INST_CNT_W'(1);
  end

  // State and retire-counter registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= S_IF;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Performance counters: active cycles and memory wait cycles
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if ((state_q == S_IF || state_q == S_MEM) && !bus.mem_ready)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.PCWrite        = ctrl.pc_write;
  assign bus.PCWriteCond    = ctrl.pc_write_cond;
  assign bus.IorD           = ctrl.iord;
  assign bus.MemRead        = ctrl.mem_read;
  assign bus.MemWrite       = ctrl.mem_write;
  assign bus.MemtoReg       = ctrl.mem_to_reg;
  assign bus.IRWrite        = ctrl.ir_write;
  assign bus.RegWrite       = ctrl.reg_write;
  assign bus.RegDst         = ctrl.reg_dst;
  assign bus.ALUSrcA        = ctrl.alu_src_a;
  assign bus.ALUSrcB        = ctrl.alu_src_b;
  assign bus.PCSource       = ctrl.pc_source;
  assign bus.ALUOp          = ctrl.alu_op;
  assign bus.output_port_en = ctrl.output_port_en;
  assign bus.illegal_inst   = ctrl.illegal_inst;
  assign bus.is_halted      = ctrl.is_halted;
  assign bus.num_inst       = num_inst_q;

endmodule
